// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA key sequencer: default prime width and FSM encoding.
package rsa_pkg;

  localparam int unsigned W_DEFAULT = 32;

  localparam logic [3:0] COLLECT_P = 4'd0;
  localparam logic [3:0] COLLECT_Q = 4'd1;
  localparam logic [3:0] MULT      = 4'd2;
  localparam logic [3:0] KG_START  = 4'd3;
  localparam logic [3:0] KG_WAIT   = 4'd4;
  localparam logic [3:0] READY     = 4'd5;
  localparam logic [3:0] MX_START  = 4'd6;
  localparam logic [3:0] MX_WAIT   = 4'd7;
  localparam logic [3:0] OUT       = 4'd8;

endpackage

// File: rtl/rsa_prime_pair_collect.sv
// Collects two distinct primes p and q from the primality tester stream.
// Identical second primes are dropped and counted.
module rsa_prime_pair_collect
  import rsa_pkg::*;
#(
  parameter int unsigned W         = W_DEFAULT,
  parameter int unsigned DUP_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 collect_p,
  input  logic                 collect_q,
  input  logic                 prime_valid,
  output logic                 prime_ready,
  input  logic [W-1:0]         prime_data,
  output logic [W-1:0]         p,
  output logic [W-1:0]         q,
  output logic                 p_take,
  output logic                 q_take,
  output logic                 dup_reject,
  output logic [DUP_CNT_W-1:0] dup_count
);

  logic xfer;
  logic is_dup;

  // Handshake and transfer qualification.
  always_comb begin
    prime_ready = collect_p | collect_q;
    xfer        = prime_valid & prime_ready;
    is_dup      = (prime_data == p);
    p_take      = xfer & collect_p;
    q_take      = xfer & collect_q & ~is_dup;
  end

  // Prime latches, duplicate pulse and saturating duplicate counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      p          <= '0;
      q          <= '0;
      dup_reject <= 1'b0;
      dup_count  <= '0;
    end else begin
      dup_reject <= 1'b0;
      if (p_take) begin
        p <= prime_data;
      end
      if (xfer && collect_q) begin
        if (is_dup) begin
          dup_reject <= 1'b1;
          if (dup_count != '1) begin
            dup_count <= dup_count + 1'b1;
          end
        end else begin
          q <= prime_data;
        end
      end
    end
  end

endmodule

// File: rtl/rsa_key_sequencer.sv
// RSA key sequencer: gathers a prime pair, drives key generation, then serves
// encrypt/decrypt requests through an external modexp engine.
module rsa_key_sequencer
  import rsa_pkg::*;
#(
  parameter int unsigned W         = W_DEFAULT,
  parameter int unsigned DUP_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 prime_valid,
  output logic                 prime_ready,
  input  logic [W-1:0]         prime_data,
  output logic                 kg_start,
  output logic [2*W-1:0]       kg_phi,
  input  logic                 kg_done,
  input  logic [2*W-1:0]       kg_e,
  input  logic [2*W-1:0]       kg_d,
  output logic                 mx_start,
  output logic [2*W-1:0]       mx_base,
  output logic [2*W-1:0]       mx_exp,
  output logic [2*W-1:0]       mx_mod,
  input  logic                 mx_done,
  input  logic [2*W-1:0]       mx_result,
  input  logic                 msg_valid,
  output logic                 msg_ready,
  input  logic [2*W-1:0]       msg_data,
  input  logic                 msg_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*W-1:0]       out_data,
  output logic                 out_err,
  input  logic                 rekey,
  output logic                 keys_valid,
  output logic [2*W-1:0]       n,
  output logic [2*W-1:0]       encrypt_key,
  output logic                 dup_reject,
  output logic [DUP_CNT_W-1:0] dup_count
);

  logic [3:0]     state;
  logic [W-1:0]   p;
  logic [W-1:0]   q;
  logic           p_take;
  logic           q_take;
  logic           run;
  logic [2*W-1:0] p_ext;
  logic [2*W-1:0] q_ext;
  logic [2*W-1:0] n_reg;
  logic [2*W-1:0] phi;
  logic [2*W-1:0] e_reg;
  logic [2*W-1:0] d_reg;
  logic [2*W-1:0] base;
  logic           mode;

  rsa_prime_pair_collect #(
    .W         (W),
    .DUP_CNT_W (DUP_CNT_W)
  ) u_collect (
    .clk         (clk),
    .rst         (rst),
    .collect_p   (run && (state == COLLECT_P)),
    .collect_q   (run && (state == COLLECT_Q)),
    .prime_valid (prime_valid),
    .prime_ready (prime_ready),
    .prime_data  (prime_data),
    .p           (p),
    .q           (q),
    .p_take      (p_take),
    .q_take      (q_take),
    .dup_reject  (dup_reject),
    .dup_count   (dup_count)
  );

  // State-decoded handshakes and latched-value presentation.
  always_comb begin
    run         = ~rst;
    p_ext       = {{W{1'b0}}, p};
    q_ext       = {{W{1'b0}}, q};
    kg_start    = run && (state == KG_START);
    kg_phi      = phi;
    mx_start    = run && (state == MX_START);
    mx_base     = base;
    mx_exp      = mode ? e_reg : d_reg;
    mx_mod      = n_reg;
    msg_ready   = run && (state == READY) && !rekey;
    out_valid   = run && (state == OUT);
    n           = keys_valid ? n_reg : '0;
    encrypt_key = keys_valid ? e_reg : '0;
  end

  // Main sequencing FSM and key/result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= COLLECT_P;
      n_reg      <= '0;
      phi        <= '0;
      e_reg      <= '0;
      d_reg      <= '0;
      base       <= '0;
      mode       <= 1'b0;
      out_data   <= '0;
      out_err    <= 1'b0;
      keys_valid <= 1'b0;
    end else begin
      case (state)
        COLLECT_P: if (p_take) state <= COLLECT_Q;
        COLLECT_Q: if (q_take) state <= MULT;
        MULT: begin
          n_reg <= p_ext * q_ext;
          phi   <= (p_ext - {{(2*W-1){1'b0}}, 1'b1}) *
                   (q_ext - {{(2*W-1){1'b0}}, 1'b1});
          state <= KG_START;
        end
        KG_START: state <= KG_WAIT;
        KG_WAIT: begin
          if (kg_done) begin
            e_reg      <= kg_e;
            d_reg      <= kg_d;
            keys_valid <= 1'b1;
            state      <= READY;
          end
        end
        READY: begin
          if (rekey) begin
            keys_valid <= 1'b0;
            state      <= COLLECT_P;
          end else if (msg_valid) begin
            if (msg_data >= n_reg) begin
              out_data <= '0;
              out_err  <= 1'b1;
              state    <= OUT;
            end else begin
              base  <= msg_data;
              mode  <= msg_mode;
              state <= MX_START;
            end
          end
        end
        MX_START: state <= MX_WAIT;
        MX_WAIT: begin
          if (mx_done) begin
            out_data <= mx_result;
            out_err  <= 1'b0;
            state    <= OUT;
          end
        end
        OUT: if (out_ready) state <= READY;
        default: state <= COLLECT_P;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_key_sequencer.sv
// Scoreboard bench for rsa_key_sequencer at W=8 with behavioural keygen/modexp engines.
module tb_rsa_key_sequencer;

  localparam int unsigned W  = 8;
  localparam int unsigned W2 = 16;

  logic          clk = 0;
  logic          rst;
  logic          prime_valid;
  logic          prime_ready;
  logic [W-1:0]  prime_data;
  logic          kg_start;
  logic [W2-1:0] kg_phi;
  logic          kg_done;
  logic [W2-1:0] kg_e, kg_d;
  logic          mx_start;
  logic [W2-1:0] mx_base, mx_exp, mx_mod;
  logic          mx_done;
  logic [W2-1:0] mx_result;
  logic          msg_valid, msg_ready, msg_mode;
  logic [W2-1:0] msg_data;
  logic          out_valid, out_ready, out_err;
  logic [W2-1:0] out_data;
  logic          rekey, keys_valid, dup_reject;
  logic [W2-1:0] n, encrypt_key;
  logic [7:0]    dup_count;

  int checks   = 0;
  int failures = 0;
  int kg_starts = 0, mx_starts = 0, dup_pulses = 0;
  bit mx_auto = 1;
  logic [W2-1:0] last_exp, last_mod;
  logic [16:0] sb_q[$];
  string       sb_name[$];

  rsa_key_sequencer #(.W(W), .DUP_CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .prime_valid(prime_valid), .prime_ready(prime_ready), .prime_data(prime_data),
    .kg_start(kg_start), .kg_phi(kg_phi), .kg_done(kg_done), .kg_e(kg_e), .kg_d(kg_d),
    .mx_start(mx_start), .mx_base(mx_base), .mx_exp(mx_exp), .mx_mod(mx_mod),
    .mx_done(mx_done), .mx_result(mx_result),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_data(msg_data), .msg_mode(msg_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
    .rekey(rekey), .keys_valid(keys_valid), .n(n), .encrypt_key(encrypt_key),
    .dup_reject(dup_reject), .dup_count(dup_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [W2-1:0] modexp(input logic [W2-1:0] b, input logic [W2-1:0] x,
                                           input logic [W2-1:0] m);
    longint unsigned r = 1;
    for (int i = W2 - 1; i >= 0; i--) begin
      r = (r * r) % m;
      if (x[i]) r = (r * b) % m;
    end
    return r[W2-1:0];
  endfunction

  // Output monitor: pops the scoreboard on each accepted output, counts pulses.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (kg_start === 1'b1) kg_starts++;
      if (mx_start === 1'b1) mx_starts++;
      if (dup_reject === 1'b1) dup_pulses++;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("unexpected_out_valid", 1, 0);
        end else begin
          logic [16:0] e;
          string nm;
          e  = sb_q.pop_front();
          nm = sb_name.pop_front();
          check({nm, "_data"}, out_data, e[15:0]);
          check({nm, "_err"}, out_err, e[16]);
        end
      end
    end
  end

  // Keygen engine model: fixed key pair after 3 cycles.
  initial begin
    kg_done = 0; kg_e = 0; kg_d = 0;
    forever begin
      @(posedge clk); #1;
      if (kg_start === 1'b1) begin
        repeat (3) @(posedge clk);
        #1 kg_done = 1; kg_e = 16'd17; kg_d = 16'd2753;
        @(posedge clk); #1 kg_done = 0;
      end
    end
  end

  // Modexp engine model: real modular exponentiation after 3 cycles.
  initial begin
    mx_done = 0; mx_result = 0;
    forever begin
      @(posedge clk); #1;
      if (mx_start === 1'b1 && mx_auto) begin
        last_exp = mx_exp;
        last_mod = mx_mod;
        repeat (3) @(posedge clk);
        #1 mx_done = 1; mx_result = modexp(mx_base, mx_exp, mx_mod);
        @(posedge clk); #1 mx_done = 0;
      end
    end
  end

  task automatic send_prime(input logic [W-1:0] v);
    for (int i = 0; i < 100 && prime_ready !== 1'b1; i++) @(negedge clk);
    check("prime_ready_wait", prime_ready, 1);
    prime_valid = 1; prime_data = v;
    @(posedge clk); #1 prime_valid = 0;
  endtask

  task automatic send_msg(input logic [W2-1:0] v, input logic m);
    for (int i = 0; i < 100 && msg_ready !== 1'b1; i++) @(negedge clk);
    check("msg_ready_wait", msg_ready, 1);
    msg_valid = 1; msg_data = v; msg_mode = m;
    @(posedge clk); #1 msg_valid = 0;
  endtask

  task automatic expect_out(input string nm, input logic [W2-1:0] d, input logic err);
    sb_q.push_back({err, d});
    sb_name.push_back(nm);
  endtask

  task automatic wait_keys();
    for (int i = 0; i < 200 && keys_valid !== 1'b1; i++) @(negedge clk);
    check("keys_valid", keys_valid, 1);
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk);
    check({nm, "_drained"}, sb_q.size(), 0);
  endtask

  task automatic check_all_zero(input string nm);
    check(nm, {prime_ready, kg_start, mx_start, msg_ready, out_valid, out_err,
               keys_valid, dup_reject, (|kg_phi), (|mx_base), (|mx_exp), (|mx_mod),
               (|out_data), (|n), (|encrypt_key), (|dup_count)}, 0);
  endtask

  initial begin
    int ks, ms;
    rst = 1; prime_valid = 0; prime_data = 0; msg_valid = 0; msg_data = 0;
    msg_mode = 0; out_ready = 1; rekey = 0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_outputs");
    rst = 0;
    @(negedge clk);

    // Key setup 61 x 53
    send_prime(8'd61);
    send_prime(8'd53);
    @(negedge clk);
    check("n_zero_before_keys", n, 0);
    wait_keys();
    check("n", n, 3233);
    check("kg_phi", kg_phi, 3120);
    check("kg_start_pulses", kg_starts, 1);
    check("encrypt_key", encrypt_key, 17);

    // Encrypt / decrypt round trip
    expect_out("enc65", 16'd2790, 0);
    send_msg(16'd65, 1);
    drain("enc65");
    check("mx_exp_enc", last_exp, 17);
    check("mx_mod_enc", last_mod, 3233);
    expect_out("dec2790", 16'd65, 0);
    send_msg(16'd2790, 0);
    drain("dec2790");
    check("mx_exp_dec", last_exp, 2753);

    // Largest in-range message: (n-1)^17 = -1 mod n
    expect_out("enc_nm1", 16'd3232, 0);
    send_msg(16'd3232, 1);
    drain("enc_nm1");

    // Out-of-range message with backpressure
    ms = mx_starts;
    out_ready = 0;
    expect_out("range_err", 16'd0, 1);
    send_msg(16'd3233, 1);
    for (int i = 0; i < 20 && out_valid !== 1'b1; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, 0);
      check("hold_err", out_err, 1);
      @(negedge clk);
    end
    out_ready = 1;
    drain("range_err");
    check("no_mx_start_on_err", mx_starts, ms);

    // Rekey wins over simultaneous message
    @(negedge clk);
    rekey = 1; msg_valid = 1; msg_data = 16'd5; msg_mode = 1;
    #1 check("msg_ready_under_rekey", msg_ready, 0);
    @(posedge clk); #1 rekey = 0; msg_valid = 0;
    @(negedge clk);
    check("rekey_keys_valid", keys_valid, 0);
    check("rekey_collect_p", prime_ready, 1);
    check("rekey_n_zero", n, 0);
    check("rekey_key_zero", encrypt_key, 0);
    repeat (5) @(negedge clk);
    check("rekey_no_mx_start", mx_starts, ms);

    // Duplicate prime rejection
    send_prime(8'd61);
    send_prime(8'd61);
    send_prime(8'd53);
    wait_keys();
    check("dup_pulses", dup_pulses, 1);
    check("dup_count", dup_count, 1);
    check("dup_n", n, 3233);
    check("dup_phi", kg_phi, 3120);

    // Reset during MX_WAIT, then stray mx_done
    mx_auto = 0;
    ms = mx_starts;
    send_msg(16'd65, 1);
    for (int i = 0; i < 20 && mx_starts == ms; i++) @(negedge clk);
    check("mx_start_seen", mx_starts, ms + 1);
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    mx_done = 1; mx_result = 16'd2790;
    @(negedge clk);
    mx_done = 0;
    check_all_zero("midop_reset_outputs");
    rst = 0;
    @(negedge clk);
    mx_done = 1;
    @(negedge clk);
    mx_done = 0;
    repeat (10) @(negedge clk);
    check("late_no_out_valid", out_valid, 0);
    check("late_keys_valid", keys_valid, 0);
    check("late_out_data", out_data, 0);
    check("late_dup_count", dup_count, 0);
    check("late_n", n, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rsa_key_sequencer.md
RSA_KEY_SEQUENCER -- requirements
Module: rsa_key_sequencer

Interface
REQ-001 SHALL have parameter W, default 32, giving the prime width in bits; all key, modulus and message values are 2W bits.
REQ-002 SHALL have parameter DUP_CNT_W, default 8, giving the width of the duplicate-prime counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; one clock, reset is synchronous and active-high.
REQ-004 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-005 SHALL have ports prime_valid (in, 1), prime_ready (out, 1) and prime_data (in, W): the prime stream from the primality tester FIFO.
REQ-006 SHALL have ports kg_start (out, 1), kg_phi (out, 2W), kg_done (in, 1), kg_e (in, 2W) and kg_d (in, 2W): the key-generation engine handshake.
REQ-007 SHALL have ports mx_start (out, 1), mx_base (out, 2W), mx_exp (out, 2W), mx_mod (out, 2W), mx_done (in, 1) and mx_result (in, 2W): the modexp engine handshake.
REQ-008 SHALL have ports msg_valid (in, 1), msg_ready (out, 1), msg_data (in, 2W) and msg_mode (in, 1; 0 = decrypt with d, 1 = encrypt with e).
REQ-009 SHALL have ports out_valid (out, 1), out_ready (in, 1), out_data (out, 2W) and out_err (out, 1).
REQ-010 SHALL have ports rekey (in, 1), keys_valid (out, 1), n (out, 2W), encrypt_key (out, 2W), dup_reject (out, 1 pulse) and dup_count (out, DUP_CNT_W).

Function
REQ-011 SHALL implement states COLLECT_P, COLLECT_Q, MULT, KG_START, KG_WAIT, READY, MX_START, MX_WAIT, OUT.
REQ-012 SHALL drive prime_ready=1 only in COLLECT_P/COLLECT_Q; a transfer occurs when prime_valid & prime_ready.
REQ-013 SHALL latch p on a transfer in COLLECT_P and move to COLLECT_Q.
REQ-014 SHALL, on a transfer in COLLECT_Q where prime_data==p, discard it, pulse dup_reject for 1 cycle, increment dup_count (saturating) and remain in COLLECT_Q; otherwise it SHALL latch q and move to MULT.
REQ-015 SHALL, in MULT, register n=p*q and phi=(p-1)*(q-1), both computed at full 2W width, in one cycle, then move to KG_START.
REQ-016 SHALL assert kg_start for exactly 1 cycle in KG_START, with kg_phi=phi held stable through KG_WAIT.
REQ-017 SHALL, in KG_WAIT on kg_done, latch kg_e/kg_d, set keys_valid=1 and move to READY; kg_done in any other state SHALL be ignored.
REQ-018 SHALL drive msg_ready=1 only in READY with rekey=0.
REQ-019 SHALL, on accepting a message with msg_data >= n, go to OUT with out_data=0 and out_err=1, without starting modexp.
REQ-020 SHALL, on accepting a message with msg_data < n, register base/mode and go to MX_START.
REQ-021 SHALL pulse mx_start for 1 cycle in MX_START, with mx_base=msg, mx_exp=(mode ? e : d) and mx_mod=n held stable until mx_done.
REQ-022 SHALL, in MX_WAIT on mx_done, latch mx_result into out_data with out_err=0 and go to OUT; result latency is therefore 2 cycles plus the modexp latency.
REQ-023 SHALL hold out_valid=1 with stable out_data/out_err in OUT until out_ready, then return to READY; out_ready=1 on entry SHALL complete the transfer in 1 cycle.
REQ-024 SHALL, when rekey=1 in READY, clear keys_valid and go to COLLECT_P; rekey SHALL take priority over a simultaneous msg_valid; rekey in any other state SHALL be ignored.
REQ-025 SHALL present n and encrypt_key as the latched values, both 0 while keys_valid=0.

Reset
REQ-026 SHALL, on rst, enter COLLECT_P and clear p, q, n, phi, e, d, dup_count and out_data to 0.
REQ-027 SHALL, on rst, drive all outputs low, and a reset mid-operation SHALL abandon any in-flight keygen or modexp without a later out_valid.

Structure
REQ-028 SHALL take the state encoding and default W from the shared package rsa_pkg.
REQ-029 SHALL place prime pair collection (REQ-012 to REQ-014) in sub-module rsa_prime_pair_collect; the multipliers SHALL remain inline.

Verification (W=8)
REQ-030 SHALL cover: primes 61, 53 -> n=3233, kg_phi=3120 and 1 kg_start pulse; keygen model returns e=17, d=2753 -> keys_valid=1, encrypt_key=17.
REQ-031 SHALL cover: msg 65 with mode=1 -> mx_exp=17, mx_mod=3233, out_data=2790, out_err=0; msg 2790 with mode=0 -> out_data=65.
REQ-032 SHALL cover: primes 61, 61, 53 -> 1 dup_reject pulse, dup_count=1, q=53, n=3233.
REQ-033 SHALL cover: msg 3233 -> out_err=1, out_data=0 and no mx_start; out_ready held low 5 cycles -> out_valid and out_data stay stable.
REQ-034 SHALL cover: rekey and msg_valid in the same READY cycle -> msg not accepted, keys_valid=0, state COLLECT_P.
REQ-035 SHALL cover: rst asserted during MX_WAIT, then a late mx_done -> no out_valid, and all outputs 0.
